// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared types and constants for the instruction fetch path
// Holds the fetcher state encoding, the HALT opcode and the default
// program-address / instruction widths used across the GPU front end.
package gpu_pkg;

    localparam int DEFAULT_PROG_ADDR_BITS = 8;
    localparam int DEFAULT_INSTR_BITS     = 8;

    // Opcode field lives in instruction bits [7:5].
    localparam logic [2:0] HALT_OPCODE = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WAIT,
        HOLD,
        DONE
    } fetch_state_t;

    function automatic logic is_halt(input logic [2:0] opcode);
        return opcode == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/instruction_fetcher.sv
// rtl/instruction_fetcher.sv - single-outstanding program-memory fetcher with output buffer
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   start, start_pc                   begin a fetch stream (from IDLE or DONE)
//   redirect_valid, redirect_pc       branch redirect
//   mem_read_valid, mem_read_address  program-memory request (one cycle per fetch)
//   mem_read_ready, mem_read_data     program-memory response strobe and data
//   instr_valid, instr, instr_pc      buffered instruction to the decoder
//   instr_ready                       decoder accepts instr
//   done                              stream terminated (HALT or end of address space)
module instruction_fetcher
    import gpu_pkg::*;
#(
    parameter int PROG_ADDR_BITS = DEFAULT_PROG_ADDR_BITS,
    parameter int INSTR_BITS     = DEFAULT_INSTR_BITS
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [PROG_ADDR_BITS-1:0] start_pc,
    input  logic                      redirect_valid,
    input  logic [PROG_ADDR_BITS-1:0] redirect_pc,
    output logic                      mem_read_valid,
    output logic [PROG_ADDR_BITS-1:0] mem_read_address,
    input  logic                      mem_read_ready,
    input  logic [INSTR_BITS-1:0]     mem_read_data,
    output logic                      instr_valid,
    output logic [INSTR_BITS-1:0]     instr,
    output logic [PROG_ADDR_BITS-1:0] instr_pc,
    input  logic                      instr_ready,
    output logic                      done
);

    fetch_state_t              state_q, state_d;
    logic [PROG_ADDR_BITS-1:0] pc_q, pc_d;
    logic                      discard_q, discard_d;
    logic [INSTR_BITS-1:0]     instr_q, instr_d;
    logic [PROG_ADDR_BITS-1:0] instr_pc_q, instr_pc_d;
    logic                      instr_valid_q, instr_valid_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            discard_q     <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            discard_q     <= discard_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        discard_d     = discard_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pc_d    = start_pc;
                    state_d = REQUEST;
                end
            end

            REQUEST: begin
                // A redirect here cancels the request before it is issued,
                // so we simply re-enter REQUEST at the new target.
                if (redirect_valid) begin
                    pc_d          = redirect_pc;
                    instr_valid_d = 1'b0;
                end else begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    // Response coinciding with the redirect is the stale one:
                    // drop it now; otherwise remember to drop it when it lands.
                    if (mem_read_ready) begin
                        discard_d = 1'b0;
                        state_d   = REQUEST;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (mem_read_ready) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = REQUEST;
                    end else if (is_halt(mem_read_data[7:5])) begin
                        state_d = DONE;
                    end else begin
                        instr_d       = mem_read_data;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = HOLD;
                    end
                end
            end

            HOLD: begin
                // Redirect takes priority over the end-of-space stop; a
                // simultaneous instr_ready still counts as consumed.
                if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    pc_d          = redirect_pc;
                    state_d       = REQUEST;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    if (&pc_q) begin
                        state_d = DONE;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = REQUEST;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign mem_read_valid   = (state_q == REQUEST) && !redirect_valid;
    assign mem_read_address = pc_q;
    assign instr_valid      = instr_valid_q;
    assign instr            = instr_q;
    assign instr_pc         = instr_pc_q;
    assign done             = (state_q == DONE);

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb/tb_instruction_fetcher.sv - directed self-checking bench for instruction_fetcher
module tb_instruction_fetcher;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] start_pc;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       mem_read_valid;
    logic [7:0] mem_read_address;
    logic       mem_read_ready;
    logic [7:0] mem_read_data;
    logic       instr_valid;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_ready;
    logic       done;

    int checks;
    int errors;
    int cycle;

    logic [7:0] mem [256];
    logic       mem_auto;
    logic       auto_ready;
    logic [7:0] auto_data;
    logic       man_ready;
    logic [7:0] man_data;
    int         req_count;
    logic [7:0] last_req_addr;

    assign mem_read_ready = mem_auto ? auto_ready : man_ready;
    assign mem_read_data  = mem_auto ? auto_data  : man_data;

    instruction_fetcher #(
        .PROG_ADDR_BITS(8),
        .INSTR_BITS    (8)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .start_pc        (start_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .mem_read_valid  (mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready  (mem_read_ready),
        .mem_read_data   (mem_read_data),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .done            (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cycle = 0;
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    // Program memory with a fixed two-cycle response latency.
    initial begin
        int         cnt;
        logic [7:0] pend_addr;
        cnt        = 0;
        pend_addr  = 8'h00;
        auto_ready = 1'b0;
        auto_data  = 8'h00;
        req_count  = 0;
        last_req_addr = 8'h00;
        forever begin
            @(negedge clk);
            auto_ready = 1'b0;
            if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    auto_ready = 1'b1;
                    auto_data  = mem[pend_addr];
                end
            end
            if (mem_read_valid) begin
                req_count++;
                last_req_addr = mem_read_address;
                pend_addr     = mem_read_address;
                cnt           = 2;
            end
        end
    end

    task automatic pulse_start(input logic [7:0] pc);
        @(negedge clk);
        start    = 1'b1;
        start_pc = pc;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %0b want 0", instr_valid); end
        checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_read_valid got %0b want 0", mem_read_valid); end
        checks++; if (mem_read_address !== 8'h00) begin errors++; $display("FAIL reset_mem_read_address got %h want 00", mem_read_address); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (instr !== 8'h00) begin errors++; $display("FAIL reset_instr got %h want 00", instr); end
        checks++; if (instr_pc !== 8'h00) begin errors++; $display("FAIL reset_instr_pc got %h want 00", instr_pc); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sequence;
        bit ok;
        int t_prev;
        int gap;
        logic [7:0] exp;
        mem[8'h10] = 8'h10;
        mem[8'h11] = 8'h11;
        mem[8'h12] = 8'h12;
        instr_ready = 1'b1;
        t_prev = 0;
        gap    = 0;
        pulse_start(8'h10);
        for (int i = 0; i < 3; i++) begin
            exp = 8'h10 + 8'(i);
            wait_valid(20, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL seq_timeout idx %0d no instr_valid", i);
            end else begin
                if (i == 1) gap = cycle - t_prev;
                t_prev = cycle;
                if (instr !== exp || instr_pc !== exp) begin
                    errors++; $display("FAIL seq_instr idx %0d got %h@%h want %h@%h", i, instr, instr_pc, exp, exp);
                end
            end
            @(negedge clk);
        end
        checks++; if (gap != 4) begin errors++; $display("FAIL seq_period got %0d want 4", gap); end
        wait_done(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL seq_done got 0 want 1"); end
    endtask

    task automatic test_stall;
        bit ok;
        int base;
        mem[8'h20] = 8'h33;
        instr_ready = 1'b0;
        pulse_start(8'h20);
        wait_valid(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_first no instr_valid"); end
        base = req_count;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr !== 8'h33 || instr_pc !== 8'h20) begin
                errors++; $display("FAIL stall_hold cyc %0d got v%0b %h@%h want v1 33@20", i, instr_valid, instr, instr_pc);
            end
            checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL stall_no_req cyc %0d got %0b want 0", i, mem_read_valid); end
        end
        checks++; if (req_count != base) begin errors++; $display("FAIL stall_req_count got %0d want %0d", req_count, base); end
        instr_ready = 1'b1;
        @(negedge clk);
        wait_done(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_done got 0 want 1"); end
    endtask

    task automatic test_halt;
        int n;
        int base;
        logic [7:0] last_pc;
        mem[8'h03] = 8'h01;
        mem[8'h04] = 8'h02;
        mem[8'h05] = 8'hE0;
        instr_ready = 1'b1;
        n = 0;
        last_pc = 8'h00;
        pulse_start(8'h03);
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            if (instr_valid) begin
                n++;
                last_pc = instr_pc;
            end
            @(negedge clk);
        end
        checks++; if (n != 2) begin errors++; $display("FAIL halt_count got %0d want 2", n); end
        checks++; if (last_pc !== 8'h04) begin errors++; $display("FAIL halt_last_pc got %h want 04", last_pc); end
        base = req_count;
        repeat (5) @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL halt_done_held got %0b want 1", done); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt_instr_valid got %0b want 0", instr_valid); end
        checks++; if (req_count != base) begin errors++; $display("FAIL halt_no_req got %0d want %0d", req_count, base); end
    endtask

    task automatic test_redirect_wait;
        bit ok;
        int base;
        mem[8'h30] = 8'h0A;
        mem[8'h40] = 8'h1B;
        instr_ready = 1'b1;
        base = req_count;
        pulse_start(8'h30);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL redir_done_cleared got %0b want 0", done); end
        checks++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h30) begin
            errors++; $display("FAIL redir_first_req got v%0b %h want v1 30", mem_read_valid, mem_read_address);
        end
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_valid(20, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL redir_timeout no instr_valid");
        end else if (instr !== 8'h1B || instr_pc !== 8'h40) begin
            errors++; $display("FAIL redir_instr got %h@%h want 1B@40", instr, instr_pc);
        end
        checks++; if (req_count - base != 2) begin errors++; $display("FAIL redir_req_count got %0d want 2", req_count - base); end
        checks++; if (last_req_addr !== 8'h40) begin errors++; $display("FAIL redir_req_addr got %h want 40", last_req_addr); end
        @(negedge clk);
        wait_done(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL redir_done got 0 want 1"); end
    endtask

    task automatic test_wrap;
        bit ok;
        int base;
        int n;
        mem[8'hFF] = 8'h42;
        mem[8'h00] = 8'h11;
        instr_ready = 1'b1;
        base = req_count;
        pulse_start(8'hFF);
        wait_valid(20, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL wrap_timeout no instr_valid");
        end else if (instr !== 8'h42 || instr_pc !== 8'hFF) begin
            errors++; $display("FAIL wrap_instr got %h@%h want 42@FF", instr, instr_pc);
        end
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (instr_valid) n++;
            @(negedge clk);
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done got %0b want 1", done); end
        checks++; if (n != 0) begin errors++; $display("FAIL wrap_extra_instr got %0d want 0", n); end
        checks++; if (req_count - base != 1) begin errors++; $display("FAIL wrap_req_count got %0d want 1", req_count - base); end
    endtask

    task automatic test_reset_wait;
        bit ok;
        mem[8'h50] = 8'h07;
        mem[8'h51] = 8'hE0;
        instr_ready = 1'b1;
        mem_auto    = 1'b0;
        man_ready   = 1'b0;
        pulse_start(8'h50);
        checks++; if (mem_read_valid !== 1'b1) begin errors++; $display("FAIL rstw_req got %0b want 1", mem_read_valid); end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_read_valid !== 1'b0 || mem_read_address !== 8'h00 || done !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL rstw_async got v%0b a%h d%0b iv%0b want all 0", mem_read_valid, mem_read_address, done, instr_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        man_ready = 1'b1;
        man_data  = 8'h07;
        @(negedge clk);
        man_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (instr_valid !== 1'b0 || mem_read_valid !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL rstw_idle cyc %0d got iv%0b mv%0b d%0b want 0 0 0", i, instr_valid, mem_read_valid, done);
            end
            @(negedge clk);
        end
        mem_auto = 1'b1;
        pulse_start(8'h50);
        wait_valid(20, ok);
        checks++;
        if (!ok || instr !== 8'h07 || instr_pc !== 8'h50) begin
            errors++; $display("FAIL rstw_restart got ok%0b %h@%h want 07@50", ok, instr, instr_pc);
        end
        @(negedge clk);
        wait_done(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstw_done got 0 want 1"); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset_n        = 1'b0;
        start          = 1'b0;
        start_pc       = 8'h00;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        instr_ready    = 1'b0;
        mem_auto       = 1'b1;
        man_ready      = 1'b0;
        man_data       = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'hE0;

        test_reset;
        test_sequence;
        test_stall;
        test_halt;
        test_redirect_wait;
        test_wrap;
        test_reset_wait;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetcher.md
INSTRUCTION_FETCHER -- requirements
Module: instruction_fetcher

Interface
REQ-001 SHALL have parameter PROG_ADDR_BITS, default 8: program-memory address width.
REQ-002 SHALL have parameter INSTR_BITS, default 8: instruction width, matching the downstream decoder input.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse, begins fetching at start_pc.
REQ-006 SHALL have port start_pc, input, PROG_ADDR_BITS: first fetch address.
REQ-007 SHALL have port redirect_valid, input, 1: branch redirect request.
REQ-008 SHALL have port redirect_pc, input, PROG_ADDR_BITS: redirect target.
REQ-009 SHALL have port mem_read_valid, output, 1: program-memory read request.
REQ-010 SHALL have port mem_read_address, output, PROG_ADDR_BITS: request address.
REQ-011 SHALL have port mem_read_ready, input, 1: response strobe; data valid this cycle.
REQ-012 SHALL have port mem_read_data, input, INSTR_BITS: returned instruction.
REQ-013 SHALL have port instr_valid, output, 1: buffered instruction available to decoder.
REQ-014 SHALL have port instr, output, INSTR_BITS: instruction to decoder.
REQ-015 SHALL have port instr_pc, output, PROG_ADDR_BITS: address of instr.
REQ-016 SHALL have port instr_ready, input, 1: decoder accepts instr this cycle.
REQ-017 SHALL have port done, output, 1: fetch stream terminated; held until next start.

Function
REQ-018 SHALL implement FSM states IDLE, REQUEST, WAIT, HOLD, DONE.
REQ-019 IDLE: start -> REQUEST with pc := start_pc; start ignored in all other states except DONE.
REQ-020 REQUEST: assert mem_read_valid=1, mem_read_address=pc for exactly one cycle, then WAIT.
REQ-021 WAIT: mem_read_valid=0; on mem_read_ready capture mem_read_data and pc into output buffer, set instr_valid=1, go HOLD.
REQ-022 HOLD: instr, instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-023 HOLD with instr_ready=1: clear instr_valid; pc := pc+1 (modulo 2^PROG_ADDR_BITS); go REQUEST next cycle.
REQ-024 Captured data with bits [7:5] == HALT_OPCODE (3'b111) SHALL NOT be presented; instr_valid stays 0; go DONE.
REQ-025 Capture at pc == all-ones (non-HALT) SHALL be presented normally; after its handshake go DONE instead of wrapping.
REQ-026 DONE: done=1, mem_read_valid=0, instr_valid=0; start -> REQUEST with new start_pc, done cleared same edge.
REQ-027 redirect_valid in REQUEST or HOLD: pc := redirect_pc, instr_valid := 0, next state REQUEST.
REQ-028 redirect_valid in WAIT: pc := redirect_pc, set discard flag; matching response dropped, then REQUEST.
REQ-029 redirect_valid in IDLE or DONE SHALL be ignored.
REQ-030 redirect_valid and instr_ready same cycle in HOLD: handshake counts as completed, then redirect applies.
REQ-031 Throughput: one instruction per 3 cycles minimum (REQUEST, WAIT with immediate ready, HOLD).
REQ-032 At most one memory request outstanding at any time.

Reset
REQ-033 reset_n=0 SHALL asynchronously force IDLE, pc=0, discard=0, instr=0, instr_pc=0, instr_valid=0, mem_read_valid=0, mem_read_address=0, done=0.
REQ-034 Reset mid-WAIT SHALL abandon the request; a late mem_read_ready after reset SHALL be ignored in IDLE.

Structure
REQ-035 Shared package gpu_pkg SHALL hold fetch_state_t enum, HALT_OPCODE, and default widths.
REQ-036 Output buffer and FSM SHALL be inline; no sub-module.

Verification
REQ-037 start, start_pc=8'h10, memory latency 2, instr_ready=1 -> instr 8'h10..8'h12 at instr_pc 10,11,12 in order.
REQ-038 instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc unchanged, no new mem_read_valid.
REQ-039 mem at 8'h05 = 8'hE0 (HALT) -> no instr_valid for it, done=1 until next start.
REQ-040 redirect_valid, redirect_pc=8'h40 during WAIT -> in-flight data dropped, next request address 8'h40.
REQ-041 start_pc=8'hFF, non-HALT data, instr_ready=1 -> one instr at instr_pc FF, then done=1, no wrap fetch.
REQ-042 reset_n low during WAIT, mem_read_ready arrives after release -> IDLE, instr_valid=0.
